// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard sequencer and the pipeline registers.
// master = sequencer (hazard inputs in, enables/flushes out); slave = pipeline.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_jump;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        irq;
  logic        irq_enable;
  logic        mem_busy;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_we;
  logic        memwb_we;
  logic        irq_take;
  logic [1:0]  state;
  logic [31:0] stall_count;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_jump, ex_mem_read, ex_rd,
    input  ex_branch_taken, irq, irq_enable, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_flush,
    output exmem_we, memwb_we, irq_take,
    output state, stall_count
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_jump, ex_mem_read, ex_rd,
    output ex_branch_taken, irq, irq_enable, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_flush,
    input  exmem_we, memwb_we, irq_take,
    input  state, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencer for PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// Ports: clk, reset (async high), hc (master: hazard in, we/flush out).
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int IRQ_HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          reset,
  pipe_hazard_ctrl_if.master hc
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    IRQ_HOLD = 2'd2
  } state_t;

  state_t      st, st_n;
  logic [1:0]  bub, bub_n;
  logic [3:0]  hold, hold_n;
  logic [31:0] scnt;
  logic        hz;
  logic        irq_ok;

  assign hz = hc.ex_mem_read
    && (hc.ex_rd != 5'd0)
    && ((hc.id_uses_rs && (hc.id_rs == hc.ex_rd))
     || (hc.id_uses_rt && (hc.id_rt == hc.ex_rd)));

  assign irq_ok = (st == RUN) && hc.irq
    && hc.irq_enable && !hz && !hc.id_jump;

  always_comb begin
    hc.pc_we      = 1'b1;
    hc.ifid_we    = 1'b1;
    hc.ifid_flush = 1'b0;
    hc.idex_flush = 1'b0;
    hc.exmem_we   = 1'b1;
    hc.memwb_we   = 1'b1;
    hc.irq_take   = 1'b0;
    st_n          = st;
    bub_n         = bub;
    hold_n        = hold;
    if (!reset) begin
      if (hc.mem_busy) begin
        hc.pc_we    = 1'b0;
        hc.ifid_we  = 1'b0;
        hc.exmem_we = 1'b0;
        hc.memwb_we = 1'b0;
      end else begin
        // Hold window runs down in parallel with any event below.
        if (st == IRQ_HOLD) begin
          hold_n = hold - 4'd1;
          if (hold <= 4'd1) st_n = RUN;
        end
        if (hc.ex_branch_taken) begin
          hc.ifid_flush = 1'b1;
          hc.idex_flush = 1'b1;
          if (st == LU_STALL) begin
            st_n  = RUN;
            bub_n = 2'd0;
          end
        end else if (st == LU_STALL) begin
          hc.pc_we      = 1'b0;
          hc.ifid_we    = 1'b0;
          hc.idex_flush = 1'b1;
          bub_n         = bub - 2'd1;
          if (bub <= 2'd1) st_n = RUN;
        end else if (irq_ok) begin
          hc.irq_take   = 1'b1;
          hc.ifid_flush = 1'b1;
          st_n          = IRQ_HOLD;
          hold_n        = 4'(IRQ_HOLDOFF);
        end else if (hc.id_jump) begin
          hc.ifid_flush = 1'b1;
        end else if (hz) begin
          hc.pc_we      = 1'b0;
          hc.ifid_we    = 1'b0;
          hc.idex_flush = 1'b1;
          // Extra bubbles only from RUN; in hold a hazard gets one.
          if (st == RUN && LU_BUBBLES > 1) begin
            st_n  = LU_STALL;
            bub_n = 2'(LU_BUBBLES - 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= RUN;
      bub  <= 2'd0;
      hold <= 4'd0;
      scnt <= 32'd0;
    end else begin
      st   <= st_n;
      bub  <= bub_n;
      hold <= hold_n;
      if (!hc.pc_we && scnt != 32'hFFFF_FFFF)
        scnt <= scnt + 32'd1;
    end
  end

  assign hc.state       = st;
  assign hc.stall_count = scnt;

endmodule
